// File: rtl/matrix_fetch_controller_pkg.sv
// ============================================================================
// Module : matrix_fetch_controller_pkg
// Brief  : Shared constants and types for the VIC-II matrix fetch controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_fetch_controller_pkg;
  localparam int NUM_CYCLES_PAL      = 63;
  localparam int NUM_CYCLES_NTSC     = 65;
  localparam int DEF_FIRST_FETCH_CYC = 14;
  localparam int DEF_RC_UPDATE_CYC   = 57;
  localparam int MATRIX_COLS         = 40;

  localparam logic [13:0] IDLE_ADDR     = 14'h3FFF;
  localparam logic [13:0] IDLE_ECM_ADDR = 14'h39FF;

  typedef struct packed {
    logic [3:0] color;
    logic [7:0] chr;
  } matrix_entry_t;

  typedef enum logic {
    ST_DISPLAY = 1'b0,
    ST_IDLE    = 1'b1
  } fetch_state_t;
endpackage

`default_nettype wire

// File: rtl/matrix_line_buffer.sv
// ============================================================================
// Module : matrix_line_buffer
// Brief  : 40x12 video matrix line buffer, sync write, comb read with bypass.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_line_buffer
  import matrix_fetch_controller_pkg::*;
(
  input  logic        clk,
  input  logic        i_we,
  input  logic [5:0]  i_waddr,
  input  logic [11:0] i_wdata,
  input  logic [5:0]  i_raddr,
  output logic [11:0] o_rdata
);
  logic [11:0] r_mem [0:MATRIX_COLS-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
endmodule

`default_nettype wire

// File: rtl/matrix_fetch_controller.sv
// ============================================================================
// Module : matrix_fetch_controller
// Brief  : VIC-II c-/g-access sequencer owning VC, VCBASE, RC, VMLI and idle.
//          Optional macro IDLE_ECM_ADDR_EN: idle g-address 39FF when ecm=1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_fetch_controller
  import matrix_fetch_controller_pkg::*;
#(
  parameter int NUM_CYCLES      = NUM_CYCLES_PAL,
  parameter int FIRST_FETCH_CYC = DEF_FIRST_FETCH_CYC,
  parameter int RC_UPDATE_CYC   = DEF_RC_UPDATE_CYC
) (
  input  logic        clk_dot4x,
  input  logic        rst,
  input  logic        clk_phi,
  input  logic        phi_phase_start_1,
  input  logic        phi_phase_start_dav,
  input  logic [6:0]  cycle_num,
  input  logic [8:0]  raster_line,
  input  logic        badline,
  input  logic        ecm,
  input  logic        bmm,
  input  logic [3:0]  vm,
  input  logic [2:0]  cb,
  input  logic [11:0] dbi,
  output logic [13:0] vic_addr,
  output logic        c_access,
  output logic        g_access,
  output logic        ba,
  output logic        idle,
  output logic [9:0]  vc,
  output logic [2:0]  rc,
  output logic [7:0]  pixels_read,
  output logic [11:0] char_read
);
  localparam logic [6:0] c_last_cyc = 7'(NUM_CYCLES - 1);
  localparam logic [6:0] c_vc_load  = 7'(FIRST_FETCH_CYC - 1);
  localparam logic [6:0] c_ba_first = 7'(FIRST_FETCH_CYC - 3);
  localparam logic [6:0] c_c_first  = 7'(FIRST_FETCH_CYC);
  localparam logic [6:0] c_c_last   = 7'(FIRST_FETCH_CYC + 39);
  localparam logic [6:0] c_g_first  = 7'(FIRST_FETCH_CYC + 1);
  localparam logic [6:0] c_g_last   = 7'(FIRST_FETCH_CYC + 40);
  localparam logic [6:0] c_rc_cyc   = 7'(RC_UPDATE_CYC);

  fetch_state_t  r_state, w_state_next;
  logic [9:0]    r_vc, r_vcbase;
  logic [2:0]    r_rc;
  logic [5:0]    r_vmli;
  logic          r_c_access, r_g_access, r_g_idle, r_ba;
  logic [13:0]   r_vic_addr;
  logic [7:0]    r_pixels;
  logic [11:0]   r_char;
  logic          w_step, w_low, w_c_cyc, w_g_cyc, w_ba_win, w_vc_load, w_rc_upd, w_buf_we;
  logic [13:0]   w_g_addr, w_idle_addr, w_addr_next;
  logic [11:0]   w_rdata;
  matrix_entry_t w_entry;

  assign w_step    = phi_phase_start_1 && (cycle_num <= c_last_cyc);
  assign w_low     = ~clk_phi;
  assign w_c_cyc   = clk_phi && badline && (cycle_num >= c_c_first) && (cycle_num <= c_c_last);
  assign w_g_cyc   = w_low && (cycle_num >= c_g_first) && (cycle_num <= c_g_last);
  assign w_ba_win  = badline && (cycle_num >= c_ba_first) && (cycle_num <= c_c_last);
  assign w_vc_load = w_low && (cycle_num == c_vc_load);
  assign w_rc_upd  = w_low && (cycle_num == c_rc_cyc);
  assign w_buf_we  = phi_phase_start_dav && r_c_access;

  matrix_line_buffer u_line_buf (
    .clk     (clk_dot4x),
    .i_we    (w_buf_we),
    .i_waddr (r_vmli),
    .i_wdata (dbi),
    .i_raddr (r_vmli),
    .o_rdata (w_rdata)
  );

  assign w_entry = w_rdata;

`ifdef IDLE_ECM_ADDR_EN
  assign w_idle_addr = ecm ? IDLE_ECM_ADDR : IDLE_ADDR;
`else
  assign w_idle_addr = IDLE_ADDR;
`endif

  always_comb begin
    w_g_addr = bmm ? {cb[2], r_vc, r_rc} : {cb, w_entry.chr, r_rc};
    if (ecm) begin
      w_g_addr[10:9] = 2'b00;
    end
    w_addr_next = IDLE_ADDR;
    if (w_c_cyc) begin
      w_addr_next = {vm, r_vc};
    end else if (w_g_cyc) begin
      w_addr_next = (r_state == ST_IDLE) ? w_idle_addr : w_g_addr;
    end
  end

  // A badline always wins over the RC==7 drop into idle.
  always_comb begin
    w_state_next = r_state;
    if (w_step) begin
      if (w_rc_upd && (r_rc == 3'd7)) begin
        w_state_next = ST_IDLE;
      end
      if (badline) begin
        w_state_next = ST_DISPLAY;
      end
    end
  end

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      r_vc       <= '0;
      r_vcbase   <= '0;
      r_rc       <= '0;
      r_vmli     <= '0;
      r_c_access <= 1'b0;
      r_g_access <= 1'b0;
      r_g_idle   <= 1'b1;
      r_ba       <= 1'b1;
      r_vic_addr <= IDLE_ADDR;
      r_pixels   <= '0;
      r_char     <= '0;
    end else if (w_step) begin
      r_c_access <= w_c_cyc;
      r_g_access <= w_g_cyc;
      r_g_idle   <= (r_state == ST_IDLE);
      r_ba       <= ~w_ba_win;
      r_vic_addr <= w_addr_next;
      if ((cycle_num == 7'd0) && (raster_line == 9'd0)) begin
        r_vcbase <= '0;
      end
      if (w_vc_load) begin
        r_vc   <= r_vcbase;
        r_vmli <= '0;
        if (badline) begin
          r_rc <= '0;
        end
      end
      if (w_rc_upd) begin
        if (r_rc == 3'd7) begin
          r_vcbase <= r_vc;
        end
        if (w_state_next == ST_DISPLAY) begin
          r_rc <= r_rc + 3'd1;
        end
      end
    end else if (phi_phase_start_dav && w_low) begin
      // Idle g-accesses still return the memory byte but never advance VC/VMLI.
      if (r_g_access) begin
        r_pixels <= dbi[7:0];
        if (!r_g_idle) begin
          r_char <= w_rdata;
          r_vc   <= r_vc + 10'd1;
          if (r_vmli != 6'd39) begin
            r_vmli <= r_vmli + 6'd1;
          end
        end else begin
          r_char <= '0;
        end
      end else begin
        r_pixels <= '0;
        r_char   <= '0;
      end
    end
  end

  assign vic_addr    = r_vic_addr;
  assign c_access    = r_c_access;
  assign g_access    = r_g_access;
  assign ba          = r_ba;
  assign idle        = (r_state == ST_IDLE);
  assign vc          = r_vc;
  assign rc          = r_rc;
  assign pixels_read = r_pixels;
  assign char_read   = r_char;
endmodule

`default_nettype wire

// File: tb/tb_matrix_fetch_controller.sv
// ============================================================================
// Module : tb_matrix_fetch_controller
// Brief  : Self-checking bench for matrix_fetch_controller with a line-level
//          reference model (honours IDLE_ECM_ADDR_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_fetch_controller;
`ifdef IDLE_ECM_ADDR_EN
  localparam bit IDLE_ECM = 1'b1;
`else
  localparam bit IDLE_ECM = 1'b0;
`endif

  logic        clk_dot4x = 1'b0;
  logic        rst, clk_phi, s1, dav, badline, ecm, bmm;
  logic [6:0]  cycle_num;
  logic [8:0]  raster_line;
  logic [3:0]  vm;
  logic [2:0]  cb;
  logic [11:0] dbi;
  logic [13:0] vic_addr;
  logic        c_access, g_access, ba, idle;
  logic [9:0]  vc;
  logic [2:0]  rc;
  logic [7:0]  pixels_read;
  logic [11:0] char_read;

  matrix_fetch_controller dut (
    .clk_dot4x(clk_dot4x), .rst(rst), .clk_phi(clk_phi),
    .phi_phase_start_1(s1), .phi_phase_start_dav(dav),
    .cycle_num(cycle_num), .raster_line(raster_line), .badline(badline),
    .ecm(ecm), .bmm(bmm), .vm(vm), .cb(cb), .dbi(dbi),
    .vic_addr(vic_addr), .c_access(c_access), .g_access(g_access), .ba(ba),
    .idle(idle), .vc(vc), .rc(rc), .pixels_read(pixels_read), .char_read(char_read)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_vc, m_vcbase, m_rc, m_vmli;
  bit          m_idle;
  logic [11:0] m_buf [40];
  int          exp_pix, exp_char;
  bit          idx_data;
  bit          g15_en;
  logic [13:0] g15_exp;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (line %0d cyc %0d phi %0b)",
               tag, act, exp, raster_line, cycle_num, clk_phi);
    end
  endtask

  task automatic model_reset();
    m_vc = 0; m_vcbase = 0; m_rc = 0; m_vmli = 0; m_idle = 1'b1;
    exp_pix = 0; exp_char = 0;
  endtask

  task automatic do_phase(input bit phi, input int cyc, input bit bl);
    bit          ec, eg, eba, gi;
    logic [13:0] ea;
    logic [11:0] d;
    int          a;
    @(negedge clk_dot4x);
    clk_phi = phi; cycle_num = cyc[6:0]; badline = bl; s1 = 1'b1;
    eba = !(bl && cyc >= 11 && cyc <= 53);
    ec  = phi && bl && cyc >= 14 && cyc <= 53;
    eg  = !phi && cyc >= 15 && cyc <= 54;
    gi  = m_idle;
    ea  = 14'h3FFF;
    if (ec) begin
      ea = {vm, m_vc[9:0]};
    end else if (eg) begin
      if (m_idle) begin
        ea = (ecm && IDLE_ECM) ? 14'h39FF : 14'h3FFF;
      end else begin
        if (bmm) a = cb[2] * 8192 + m_vc * 8 + m_rc;
        else     a = cb * 2048 + m_buf[m_vmli][7:0] * 8 + m_rc;
        if (ecm) a = a & ~32'h600;
        ea = a[13:0];
      end
    end
    if (raster_line == 0 && cyc == 0) m_vcbase = 0;
    if (!phi && cyc == 13) begin
      m_vc = m_vcbase; m_vmli = 0;
      if (bl) m_rc = 0;
    end
    if (!phi && cyc == 57) begin
      if (m_rc == 7) begin m_idle = 1'b1; m_vcbase = m_vc; end
      if (bl) m_idle = 1'b0;
      if (!m_idle) m_rc = (m_rc + 1) % 8;
    end
    if (bl) m_idle = 1'b0;
    @(negedge clk_dot4x);
    s1 = 1'b0;
    check_eq("ba", ba, eba);
    check_eq("c_access", c_access, ec);
    check_eq("g_access", g_access, eg);
    check_eq("vic_addr", vic_addr, ea);
    check_eq("idle", idle, m_idle);
    check_eq("rc", rc, m_rc);
    if (g15_en && eg && cyc == 15) check_eq("g15_addr_const", vic_addr, g15_exp);
    d = 12'($urandom);
    if (ec && idx_data) d = 12'h100 + 12'(m_vmli);
    dbi = d; dav = 1'b1;
    @(negedge clk_dot4x);
    dav = 1'b0;
    if (ec) m_buf[m_vmli] = d;
    if (!phi) begin
      if (eg) begin
        exp_pix = d[7:0];
        if (gi) exp_char = 0;
        else begin
          exp_char = m_buf[m_vmli];
          m_vc = (m_vc + 1) % 1024;
          if (m_vmli < 39) m_vmli++;
        end
      end else begin
        exp_pix = 0; exp_char = 0;
      end
    end
    check_eq("pixels_read", pixels_read, exp_pix);
    check_eq("char_read", char_read, exp_char);
    check_eq("vc", vc, m_vc);
    @(negedge clk_dot4x);
  endtask

  task automatic run_line(input int line, input bit bl, input int drop, input int stop);
    bit b;
    raster_line = line[8:0];
    for (int c = 0; c < stop; c++) begin
      b = bl && (c < drop);
      do_phase(1'b0, c, b);
      do_phase(1'b1, c, b);
    end
  endtask

  initial begin
    rst = 1'b1; clk_phi = 1'b0; s1 = 1'b0; dav = 1'b0; badline = 1'b0;
    ecm = 1'b0; bmm = 1'b0; vm = 4'h1; cb = 3'b000; dbi = '0;
    cycle_num = '0; raster_line = '0; idx_data = 1'b0; g15_en = 1'b0; g15_exp = '0;
    for (int i = 0; i < 40; i++) m_buf[i] = '0;
    model_reset();
    repeat (4) @(negedge clk_dot4x);
    check_eq("rst_vic_addr", vic_addr, 14'h3FFF);
    check_eq("rst_ba", ba, 1'b1);
    check_eq("rst_idle", idle, 1'b1);
    check_eq("rst_vc", vc, 10'd0);
    check_eq("rst_rc", rc, 3'd0);
    check_eq("rst_c_g", {c_access, g_access}, 2'b00);
    check_eq("rst_pix_char", {pixels_read, char_read}, 20'd0);
    rst = 1'b0;

    run_line(0, 1'b0, 0, 63);
    check_eq("noline_idle", idle, 1'b1);
    check_eq("noline_vc", vc, 10'd0);

    idx_data = 1'b1;
    run_line(1, 1'b1, 63, 63);
    idx_data = 1'b0;
    for (int l = 2; l <= 8; l++) run_line(l, 1'b0, 0, 63);
    check_eq("rc7_to_idle", idle, 1'b1);

    run_line(9, 1'b1, 63, 63);
    run_line(10, 1'b0, 0, 63);
    run_line(11, 1'b0, 0, 63);
    bmm = 1'b1; cb = 3'b100; g15_en = 1'b1; g15_exp = 14'h2143;
    run_line(12, 1'b0, 0, 63);
    ecm = 1'b1; g15_exp = 14'h2144;
    run_line(13, 1'b0, 0, 63);
    ecm = 1'b0; bmm = 1'b0; cb = 3'b000; g15_en = 1'b0;
    for (int l = 14; l <= 16; l++) run_line(l, 1'b0, 0, 63);
    ecm = 1'b1; g15_en = 1'b1; g15_exp = IDLE_ECM ? 14'h39FF : 14'h3FFF;
    run_line(17, 1'b0, 0, 63);
    g15_en = 1'b0; ecm = 1'b0;

    for (int l = 18; l < 26; l++) begin
      ecm = 1'($urandom); bmm = 1'($urandom);
      vm = 4'($urandom); cb = 3'($urandom);
      run_line(l, 1'($urandom_range(0, 1)), $urandom_range(10, 63), 63);
    end

    ecm = 1'b0; bmm = 1'b0;
    run_line(30, 1'b1, 63, 30);
    @(negedge clk_dot4x);
    rst = 1'b1;
    #1;
    check_eq("midrst_ba", ba, 1'b1);
    check_eq("midrst_vc", vc, 10'd0);
    check_eq("midrst_idle", idle, 1'b1);
    check_eq("midrst_addr", vic_addr, 14'h3FFF);
    model_reset();
    @(negedge clk_dot4x);
    rst = 1'b0;
    run_line(31, 1'b0, 0, 63);
    check_eq("post_rst_idle", idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
